// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and sizing constants for the 4:1 mux scan sequencer.
package mux_scan_sequencer_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;
   localparam int CNT_W  = 4;
endpackage

// File: rtl/mux_scan_sequencer_settle_timer.sv
// Loadable down-counter that saturates at zero; zero flags the end of a settle window.
module settle_timer
   import mux_scan_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives a 4-bit word and each select code onto a 4:1 mux, waits for the gates to
// settle, samples the mux output per channel and reassembles the word.
module mux_scan_sequencer
   import mux_scan_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_CH-1:0] data_in,
   output logic              ready,
   output logic              busy,
   output logic [NUM_CH-1:0] mux_data,
   output logic [SEL_W-1:0]  mux_sel,
   input  logic              mux_out,
   output logic [NUM_CH-1:0] result,
   output logic              valid,
   output logic              mismatch
);

   // The timer counts down to zero inside SETTLE, so it is loaded one short of the hold time.
   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
   localparam state_e CH_ENTRY = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [NUM_CH-1:0]  data_q, data_d;
   logic [NUM_CH-1:0]  result_q, result_d;
   logic               mismatch_q, mismatch_d;
   logic               timer_load;
   logic               timer_zero;

   settle_timer u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (SETTLE_LOAD),
      .zero     (timer_zero)
   );

   // NOTE: every variable gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      data_d     = data_q;
      result_d   = result_q;
      mismatch_d = mismatch_q;
      timer_load = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               data_d     = data_in;
               sel_d      = '0;
               result_d   = '0;
               mismatch_d = 1'b0;
               timer_load = 1'b1;
               state_d    = CH_ENTRY;
            end
         end
         ST_SETTLE: begin
            if (timer_zero) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            result_d[sel_q] = mux_out;
            mismatch_d      = mismatch_q | (mux_out != data_q[sel_q]);
            if (sel_q == LAST_SEL) begin
               state_d = ST_DONE;
            end else begin
               sel_d      = sel_q + 1'b1;
               timer_load = 1'b1;
               state_d    = CH_ENTRY;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         data_q     <= '0;
         result_q   <= '0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         data_q     <= data_d;
         result_q   <= result_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign ready    = (state_q == ST_IDLE);
   assign busy     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
   assign valid    = (state_q == ST_DONE);
   assign mux_data = data_q;
   assign mux_sel  = sel_q;
   assign result   = result_q;
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: two sequencers (settle 2 and settle 0) each driving an ideal mux model,
// checked cycle by cycle against a scan-position model and per scan against a result queue.
module tb_mux_scan_sequencer;

   localparam int S0 = 2;
   localparam int S1 = 0;

   typedef struct {
      logic [3:0] res;
      logic       mis;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      start;
   logic [1:0]      force_zero;
   logic [1:0]      ready, busy, valid, mismatch, mux_out;
   logic [1:0][3:0] data_in, mux_data, result;
   logic [1:0][1:0] mux_sel;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: phase is -1 when idle, else the cycle index since the accepting edge.
   int         phase    [2] = '{-1, -1};
   logic [3:0] cap      [2] = '{4'h0, 4'h0};
   logic       fz_cap   [2] = '{1'b0, 1'b0};
   logic [1:0] idle_sel [2] = '{2'd0, 2'd0};
   int         idle_n   [2] = '{0, 0};
   exp_t       q0[$];
   exp_t       q1[$];
   exp_t       sb_e;

   always #5 clk = ~clk;

   mux_scan_sequencer #(.SETTLE_CYCLES(S0)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .data_in(data_in[0]),
      .ready(ready[0]), .busy(busy[0]), .mux_data(mux_data[0]), .mux_sel(mux_sel[0]),
      .mux_out(mux_out[0]), .result(result[0]), .valid(valid[0]), .mismatch(mismatch[0])
   );

   mux_scan_sequencer #(.SETTLE_CYCLES(S1)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .data_in(data_in[1]),
      .ready(ready[1]), .busy(busy[1]), .mux_data(mux_data[1]), .mux_sel(mux_sel[1]),
      .mux_out(mux_out[1]), .result(result[1]), .valid(valid[1]), .mismatch(mismatch[1])
   );

   assign mux_out[0] = force_zero[0] ? 1'b0 : mux_data[0][mux_sel[0]];
   assign mux_out[1] = force_zero[1] ? 1'b0 : mux_data[1][mux_sel[1]];

   function automatic int sc(input int i);
      return (i == 0) ? S0 : S1;
   endfunction

   function automatic int scan_len(input int i);
      return 4 * (sc(i) + 1);
   endfunction

   function automatic exp_t mk_exp(input logic [3:0] d, input logic fz);
      exp_t e;
      e.res = fz ? 4'h0 : d;
      e.mis = fz && (d != 4'h0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            phase[i]    <= -1;
            cap[i]      <= 4'h0;
            fz_cap[i]   <= 1'b0;
            idle_sel[i] <= 2'd0;
            idle_n[i]   <= 0;
         end
         q0.delete();
         q1.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (phase[i] < 0) begin
               if (start[i] === 1'b1) begin
                  phase[i]  <= 0;
                  cap[i]    <= data_in[i];
                  fz_cap[i] <= force_zero[i];
                  if (i == 0) q0.push_back(mk_exp(data_in[i], force_zero[i]));
                  else        q1.push_back(mk_exp(data_in[i], force_zero[i]));
               end
            end else if (phase[i] == scan_len(i)) begin
               phase[i]    <= -1;
               idle_sel[i] <= 2'd3;
               idle_n[i]   <= 4;
            end else begin
               phase[i] <= phase[i] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         automatic int         ph  = phase[i];
         automatic int         per = sc(i) + 1;
         automatic int         len = 4 * per;
         automatic int         n   = (ph < 0) ? idle_n[i] : ((ph / per > 4) ? 4 : ph / per);
         automatic logic [1:0] es  = (ph < 0) ? idle_sel[i] : ((ph / per > 3) ? 2'd3 : 2'(ph / per));
         automatic logic [3:0] er  = 4'h0;
         automatic logic       em  = 1'b0;
         for (int c = 0; c < 4; c++) begin
            if (c < n) begin
               er[c] = fz_cap[i] ? 1'b0 : cap[i][c];
               em    = em | (er[c] != cap[i][c]);
            end
         end
         check($sformatf("u%0d ready", i),    32'(ready[i]),    32'(ph < 0));
         check($sformatf("u%0d busy", i),     32'(busy[i]),     32'(ph >= 0 && ph < len));
         check($sformatf("u%0d valid", i),    32'(valid[i]),    32'(ph == len));
         check($sformatf("u%0d mux_sel", i),  32'(mux_sel[i]),  32'(es));
         check($sformatf("u%0d mux_data", i), 32'(mux_data[i]), 32'(cap[i]));
         check($sformatf("u%0d result", i),   32'(result[i]),   32'(er));
         check($sformatf("u%0d mismatch", i), 32'(mismatch[i]), 32'(em));
         if (valid[i] === 1'b1) begin
            if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
               check($sformatf("u%0d sb_pending", i), 32'd0, 32'd1);
            end else begin
               sb_e = (i == 0) ? q0.pop_front() : q1.pop_front();
               check($sformatf("u%0d sb_result", i),   32'(result[i]),   32'(sb_e.res));
               check($sformatf("u%0d sb_mismatch", i), 32'(mismatch[i]), 32'(sb_e.mis));
            end
         end
      end
   end

   task automatic wait_phase(input int i, input int target);
      int k;
      k = 0;
      while (phase[i] != target && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (phase[i] != target) check($sformatf("u%0d wait_timeout", i), 32'(phase[i]), 32'(target));
   endtask

   // noise: 0 none, 1 random start pulses while busy, 2 one start with data 0 at phase 2.
   task automatic scan(input int i, input logic [3:0] d, input logic fz, input int noise);
      wait_phase(i, -1);
      force_zero[i] = fz;
      data_in[i]    = d;
      start[i]      = 1'b1;
      @(negedge clk);
      start[i]   = 1'b0;
      data_in[i] = 4'($urandom);
      for (int k = 0; k < 200 && phase[i] >= 0; k++) begin
         start[i] = 1'b0;
         if (phase[i] < scan_len(i)) begin
            if (noise == 1 && $urandom_range(0, 2) == 0) begin
               start[i]   = 1'b1;
               data_in[i] = 4'($urandom);
            end
            if (noise == 2 && phase[i] == 2) begin
               start[i]   = 1'b1;
               data_in[i] = 4'h0;
            end
         end
         @(negedge clk);
      end
      start[i] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      start      = '0;
      data_in    = '0;
      force_zero = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      scan(0, 4'hE, 1'b0, 0);

      // Back-to-back: a start held through DONE is only taken once IDLE is reached.
      wait_phase(0, -1);
      data_in[0] = 4'hA;
      start[0]   = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_phase(0, scan_len(0));
      data_in[0] = 4'hB;
      start[0]   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start[0] = 1'b0;

      scan(0, 4'hB, 1'b1, 0);
      scan(0, 4'hC, 1'b0, 2);

      // Asynchronous reset in the middle of channel 2's settle window.
      wait_phase(0, -1);
      data_in[0] = 4'h9;
      start[0]   = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_phase(0, 2 * (S0 + 1));
      #2 rst = 1'b1;
      #1;
      check("rst ready",    32'(ready[0]),    32'd1);
      check("rst busy",     32'(busy[0]),     32'd0);
      check("rst valid",    32'(valid[0]),    32'd0);
      check("rst mux_sel",  32'(mux_sel[0]),  32'd0);
      check("rst mux_data", 32'(mux_data[0]), 32'd0);
      check("rst result",   32'(result[0]),   32'd0);
      check("rst mismatch", 32'(mismatch[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      scan(0, 4'h5, 1'b0, 0);
      scan(1, 4'h6, 1'b0, 0);

      repeat (40) begin
         scan(int'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) == 0), 1);
      end

      wait_phase(0, -1);
      wait_phase(1, -1);
      @(negedge clk);
      check("u0 sb_drained", 32'(q0.size()), 32'd0);
      check("u1 sb_drained", 32'(q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
